// File: rtl/clb_stream_pipe.sv
// Streaming leading-bit counter: a registered B-ary priority tree that returns the number of
// MSB-side bits preceding the first bit equal to a per-beat LEAD value, with valid/ready and a tag.
module clb_stream_pipe #(
  parameter int unsigned W_IN      = 32,
  parameter int unsigned BRANCHES  = 2,
  parameter int unsigned REG_EVERY = 1,
  parameter int unsigned TAG_W     = 8,
  localparam int unsigned CNT_W    = $clog2(W_IN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  in_vec,
  input  logic             in_lead,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_found,
  output logic [TAG_W-1:0] out_tag
);

  function automatic int unsigned calc_levels(input int unsigned w, input int unsigned b);
    int unsigned     l;
    longint unsigned p;
    l = 0;
    p = 1;
    if (b < 2) return 1;
    while (p < 64'(w)) begin
      p = p * 64'(b);
      l = l + 1;
    end
    return l;
  endfunction

  localparam int unsigned LB     = (BRANCHES == 4) ? 2 : 1;
  localparam int unsigned BR     = 1 << LB;
  localparam int unsigned LEVELS = calc_levels(W_IN, BR);
  localparam int unsigned CW     = LEVELS * LB;
  localparam int unsigned CLB_IN = 1 << CW;
  localparam int unsigned STAGES = (LEVELS + REG_EVERY - 1) / REG_EVERY;
  localparam int unsigned NMID   = (STAGES > 1) ? STAGES - 1 : 1;

  if (BRANCHES != 2 && BRANCHES != 4) begin : g_bad_branches
    $error("clb_stream_pipe: BRANCHES must be 2 or 4");
  end

  typedef logic [CW-1:0]          cnt_t;
  typedef cnt_t [CLB_IN-1:0]      cnt_vec_t;
  typedef logic [CLB_IN-1:0]      fnd_vec_t;

  // Intermediate slices; LEAD is consumed at the leaves, so only found/cnt travel on.
  logic [NMID-1:0]  vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [NMID];
  logic [TAG_W-1:0] tag_d [NMID];
  fnd_vec_t         pf_q  [NMID];
  fnd_vec_t         pf_d  [NMID];
  cnt_vec_t         pc_q  [NMID];
  cnt_vec_t         pc_d  [NMID];

  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] out_cnt_q,   out_cnt_d;
  logic             out_found_q, out_found_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;

  logic stall_c;

  assign stall_c   = out_valid_q & ~out_ready;
  assign in_ready  = ~stall_c;
  assign out_valid = out_valid_q;
  assign out_cnt   = out_cnt_q;
  assign out_found = out_found_q;
  assign out_tag   = out_tag_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned LO = s * REG_EVERY;
    localparam int unsigned HI = (LO + REG_EVERY < LEVELS) ? LO + REG_EVERY : LEVELS;

    logic             v_in;
    logic [TAG_W-1:0] t_in;
    fnd_vec_t         f_in, f_out;
    cnt_vec_t         c_in, c_out;

    if (s == 0) begin : g_leaf
      logic [CLB_IN-1:0] pad_vec;

      // LSB-side padding uses ~lead so it can never be reported as a match.
      if (CLB_IN > W_IN) begin : g_pad
        assign pad_vec = {in_vec, {(CLB_IN - W_IN){~in_lead}}};
      end else begin : g_nopad
        assign pad_vec = in_vec;
      end

      always_comb begin
        f_in = '0;
        for (int k = 0; k < CLB_IN; k++) begin
          f_in[k] = ~(pad_vec[CLB_IN-1-k] ^ in_lead);
        end
      end

      assign c_in = '0;
      assign v_in = in_valid;
      assign t_in = in_tag;
    end else begin : g_from_reg
      assign f_in = pf_q[s-1];
      assign c_in = pc_q[s-1];
      assign v_in = vld_q[s-1];
      assign t_in = tag_q[s-1];
    end

    // Tree levels LO..HI-1; node 0 is the MSB side, lowest-index found child wins.
    always_comb begin : combine
      fnd_vec_t nf;
      cnt_vec_t nc;
      f_out = f_in;
      c_out = c_in;
      nf    = '0;
      nc    = '0;
      for (int unsigned lvl = LO; lvl < HI; lvl++) begin
        nf = '0;
        nc = '0;
        for (int unsigned i = 0; i < CLB_IN / BR; i++) begin
          for (int j = BR - 1; j >= 0; j--) begin
            if (f_out[i*BR + j]) begin
              nf[i] = 1'b1;
              nc[i] = (cnt_t'(j) << (lvl * LB)) | c_out[i*BR + j];
            end
          end
        end
        f_out = nf;
        c_out = nc;
      end
    end

    if (s < STAGES - 1) begin : g_mid
      assign vld_d[s] = stall_c ? vld_q[s] : v_in;
      assign tag_d[s] = stall_c ? tag_q[s] : t_in;
      assign pf_d[s]  = stall_c ? pf_q[s]  : f_out;
      assign pc_d[s]  = stall_c ? pc_q[s]  : c_out;
    end else begin : g_last
      logic found_c;
      cnt_t root_c;

      // After the last level only node 0 can be non-zero, so folding all nodes yields the root.
      always_comb begin
        found_c = |f_out;
        root_c  = '0;
        for (int unsigned i = 0; i < CLB_IN; i++) begin
          root_c = root_c | c_out[i];
        end
      end

      assign out_valid_d = stall_c ? out_valid_q : v_in;
      assign out_found_d = stall_c ? out_found_q : found_c;
      assign out_cnt_d   = stall_c ? out_cnt_q
                                   : (found_c ? CNT_W'(root_c) : CNT_W'(W_IN));
      assign out_tag_d   = stall_c ? out_tag_q : t_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      for (int s = 0; s < NMID; s++) begin
        tag_q[s] <= '0;
        pf_q[s]  <= '0;
        pc_q[s]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_cnt_q   <= '0;
      out_found_q <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      vld_q       <= vld_d;
      for (int s = 0; s < NMID; s++) begin
        tag_q[s] <= tag_d[s];
        pf_q[s]  <= pf_d[s];
        pc_q[s]  <= pc_d[s];
      end
      out_valid_q <= out_valid_d;
      out_cnt_q   <= out_cnt_d;
      out_found_q <= out_found_d;
      out_tag_q   <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_clb_stream_pipe.sv
// Directed bench for clb_stream_pipe: a W_IN=12 radix-2 instance and a W_IN=33 radix-4 instance.
module tb_clb_stream_pipe;

  logic clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_lead, a_out_valid, a_out_ready, a_found;
  logic [11:0] a_vec;
  logic [7:0]  a_tag, a_out_tag;
  logic [3:0]  a_cnt;

  logic        b_in_valid, b_in_ready, b_lead, b_out_valid, b_out_ready, b_found;
  logic [32:0] b_vec;
  logic [7:0]  b_tag, b_out_tag;
  logic [5:0]  b_cnt;

  int n_vec = 0;
  int n_bad = 0;

  clb_stream_pipe #(.W_IN(12), .BRANCHES(2), .REG_EVERY(1), .TAG_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_vec), .in_lead(a_lead),
    .in_tag(a_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_cnt(a_cnt), .out_found(a_found), .out_tag(a_out_tag)
  );

  clb_stream_pipe #(.W_IN(33), .BRANCHES(4), .REG_EVERY(2), .TAG_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_vec), .in_lead(b_lead),
    .in_tag(b_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_cnt(b_cnt), .out_found(b_found), .out_tag(b_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_clb(input logic [11:0] v, input logic l);
    for (int b = 11; b >= 0; b--) begin
      if (v[b] == l) return 11 - b;
    end
    return 12;
  endfunction

  task automatic run_a(input string nm, input logic [11:0] v, input logic l,
                       input logic [7:0] t, input int ecnt, input logic efnd);
    int lat;
    lat = 0;
    @(negedge clk);
    a_vec = v; a_lead = l; a_tag = t; a_in_valid = 1'b1;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (a_out_valid) begin
        lat = c;
        break;
      end
    end
    check({nm, "_lat"}, lat, 4);
    check({nm, "_cnt"}, a_cnt, ecnt);
    check({nm, "_found"}, a_found, efnd);
    check({nm, "_tag"}, a_out_tag, t);
  endtask

  task automatic run_b(input string nm, input logic [32:0] v, input logic l,
                       input logic [7:0] t, input int ecnt, input logic efnd);
    int lat;
    lat = 0;
    @(negedge clk);
    b_vec = v; b_lead = l; b_tag = t; b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (b_out_valid) begin
        lat = c;
        break;
      end
    end
    check({nm, "_lat"}, lat, 2);
    check({nm, "_cnt"}, b_cnt, ecnt);
    check({nm, "_found"}, b_found, efnd);
    check({nm, "_tag"}, b_out_tag, t);
  endtask

  typedef struct {
    int         cnt;
    logic       fnd;
    logic [7:0] tag;
  } exp_t;

  initial begin
    exp_t       q[$];
    exp_t       e;
    logic [7:0] g_tag [4];
    logic [3:0] g_cnt [4];
    logic       g_fnd [4];
    int         g_cyc [4];
    int         n, sent, rcvd, cyc, extra;
    logic       stalled, s_fnd;
    logic [3:0] s_cnt;
    logic [7:0] s_tag;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_vec = '0; a_lead = 1'b0; a_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_vec = '0; b_lead = 1'b0; b_tag = '0; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_cnt", a_cnt, 0);
    check("rst_out_found", a_found, 0);
    check("rst_out_tag", a_out_tag, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_in_ready", b_in_ready, 1);
    rst_n = 1'b1;

    // single beats and boundaries
    run_a("t1", 12'h0F0, 1'b1, 8'hA5, 4, 1'b1);
    run_a("t2_zero", 12'h000, 1'b1, 8'h01, 12, 1'b0);
    run_a("t2_ones", 12'hFFF, 1'b0, 8'h02, 12, 1'b0);
    run_a("msb", 12'h800, 1'b1, 8'h03, 0, 1'b1);
    run_a("lsb1", 12'h001, 1'b1, 8'h04, 11, 1'b1);
    run_a("lsb0", 12'hFFE, 1'b0, 8'h05, 11, 1'b1);
    run_a("mid0", 12'hF3F, 1'b0, 8'h06, 4, 1'b1);

    // back-to-back, alternating LEAD
    @(negedge clk);
    a_vec = 12'h800; a_lead = 1'b1; a_tag = 8'h31; a_in_valid = 1'b1;
    @(posedge clk);
    #1 a_vec = 12'h7FF; a_lead = 1'b0; a_tag = 8'h32;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (a_out_valid && n < 4) begin
        g_tag[n] = a_out_tag; g_cnt[n] = a_cnt; g_fnd[n] = a_found; g_cyc[n] = c;
        n++;
      end
    end
    check("b2b_count", n, 2);
    check("b2b_tag0", g_tag[0], 8'h31);
    check("b2b_tag1", g_tag[1], 8'h32);
    check("b2b_cnt0", g_cnt[0], 0);
    check("b2b_cnt1", g_cnt[1], 0);
    check("b2b_fnd0", g_fnd[0], 1);
    check("b2b_fnd1", g_fnd[1], 1);
    check("b2b_cyc0", g_cyc[0], 3);
    check("b2b_cyc1", g_cyc[1], 4);

    // random beats with random backpressure
    sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0;
    s_cnt = '0; s_fnd = 1'b0; s_tag = '0;
    while (rcvd < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("stall_valid", a_out_valid, 1);
        check("stall_cnt", a_cnt, s_cnt);
        check("stall_found", a_found, s_fnd);
        check("stall_tag", a_out_tag, s_tag);
      end
      a_out_ready = 1'($urandom_range(0, 1));
      a_in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
      a_vec       = 12'($urandom);
      a_lead      = 1'($urandom);
      a_tag       = 8'(8'h40 + sent);
      #1;
      check("rand_in_ready", a_in_ready, !(a_out_valid && !a_out_ready));
      if (a_out_valid && a_out_ready) begin
        check("rand_q_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("rand_cnt", a_cnt, e.cnt);
          check("rand_found", a_found, e.fnd);
          check("rand_tag", a_out_tag, e.tag);
        end
        rcvd++;
      end
      if (a_in_valid && a_in_ready) begin
        e.cnt = ref_clb(a_vec, a_lead);
        e.fnd = (e.cnt != 12);
        e.tag = a_tag;
        q.push_back(e);
        sent++;
      end
      stalled = a_out_valid && !a_out_ready;
      s_cnt = a_cnt; s_fnd = a_found; s_tag = a_out_tag;
    end
    check("rand_received", rcvd, 20);
    @(negedge clk);
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // reset with beats in flight
    a_vec = 12'h0F0; a_lead = 1'b1; a_tag = 8'h51; a_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 a_tag = 8'(8'h52 + i);
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", a_out_valid, 1);
    check("pre_rst_tag", a_out_tag, 8'h51);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", a_out_valid, 0);
    check("mid_rst_in_ready", a_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_a("post_rst", 12'h040, 1'b1, 8'h77, 5, 1'b1);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_out_valid) extra++;
    end
    check("post_rst_extra", extra, 0);

    // radix-4 instance: single-one walk plus no-match cases
    for (int p = 0; p < 33; p++) begin
      run_b("walk", 33'd1 << (32 - p), 1'b1, 8'(p), p, 1'b1);
    end
    run_b("b_zero", 33'd0, 1'b1, 8'hE0, 33, 1'b0);
    run_b("b_ones", {33{1'b1}}, 1'b0, 8'hE1, 33, 1'b0);
    run_b("b_lsb0", {{32{1'b1}}, 1'b0}, 1'b0, 8'hE2, 32, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
